// File: rtl/axi4_scratch_slave.sv
// axi4_scratch_slave: single-beat AXI4 responder in front of a small
// full-width scratch RAM. It stores and returns whole 64-byte words with
// byte strobes. Bursts (LEN != 0) get SLVERR, and out-of-range addresses
// get DECERR.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET        clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_AWREADY        write address channel
//   S_AXI_W*  / S_AXI_WREADY         write data channel
//   S_AXI_B*  / S_AXI_BREADY         write response channel
//   S_AXI_AR* / S_AXI_ARREADY        read address channel
//   S_AXI_R*  / S_AXI_RREADY         read data channel
// AxSIZE/AxBURST/AxLOCK/AxCACHE/AxQOS/AxPROT are accepted but have no effect.
module axi4_scratch_slave #(
    parameter int unsigned AXI_DATA_WIDTH = 512,
    parameter int unsigned AXI_ADDR_WIDTH = 34,
    parameter int unsigned DEPTH          = 16
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESET,
    // write address
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                        S_AXI_AWVALID,
    input  logic [3:0]                  S_AXI_AWID,
    input  logic [7:0]                  S_AXI_AWLEN,
    input  logic [2:0]                  S_AXI_AWSIZE,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic                        S_AXI_AWLOCK,
    input  logic [3:0]                  S_AXI_AWCACHE,
    input  logic [3:0]                  S_AXI_AWQOS,
    input  logic [2:0]                  S_AXI_AWPROT,
    output logic                        S_AXI_AWREADY,
    // write data
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WLAST,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    // write response
    output logic [3:0]                  S_AXI_BID,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    // read address
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    input  logic [3:0]                  S_AXI_ARID,
    input  logic [7:0]                  S_AXI_ARLEN,
    input  logic [2:0]                  S_AXI_ARSIZE,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic                        S_AXI_ARLOCK,
    input  logic [3:0]                  S_AXI_ARCACHE,
    input  logic [3:0]                  S_AXI_ARQOS,
    input  logic [2:0]                  S_AXI_ARPROT,
    output logic                        S_AXI_ARREADY,
    // read data
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [3:0]                  S_AXI_RID,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RLAST,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY
);

    localparam int unsigned STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned IDX_LSB = $clog2(STRB_W);
    localparam int unsigned HI_LSB  = IDX_LSB + IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_ADDR, R_DATA}         r_state_t;

    // Response code for an address/length pair; a burst wins over a bad address.
    function automatic logic [1:0] resp_code(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                             input logic [7:0]                len);
        logic [1:0] code;
        code = RESP_OKAY;
        if (len != 8'd0)
            code = RESP_SLVERR;
        else if (addr[AXI_ADDR_WIDTH-1:HI_LSB] != '0)
            code = RESP_DECERR;
        return code;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t         w_state, w_next;
    r_state_t         r_state, r_next;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_code;
    logic [7:0]       r_len;
    logic [7:0]       r_cnt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [1:0] aw_code, ar_code;
    logic [AXI_DATA_WIDTH-1:0] wmask;

    assign aw_hs   = S_AXI_AWREADY & S_AXI_AWVALID;
    assign w_hs    = S_AXI_WREADY  & S_AXI_WVALID;
    assign b_hs    = S_AXI_BVALID  & S_AXI_BREADY;
    assign ar_hs   = S_AXI_ARREADY & S_AXI_ARVALID;
    assign r_hs    = S_AXI_RVALID  & S_AXI_RREADY;
    assign aw_code = resp_code(S_AXI_AWADDR, S_AXI_AWLEN);
    assign ar_code = resp_code(S_AXI_ARADDR, S_AXI_ARLEN);

    // Sideband fields and byte-offset bits intentionally have no effect.
    logic unused_sideband;
    assign unused_sideband = ^{S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK, S_AXI_AWCACHE,
                               S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_ARSIZE, S_AXI_ARBURST,
                               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT,
                               S_AXI_AWADDR[IDX_LSB-1:0], S_AXI_ARADDR[IDX_LSB-1:0]};

    // Byte strobes expanded to a bit mask.
    for (genvar g = 0; g < STRB_W; g++) begin : g_wmask
        assign wmask[g*8 +: 8] = {8{S_AXI_WSTRB[g]}};
    end

    // Write FSM next state.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_ADDR:  if (aw_hs)                w_next = W_DATA;
            W_DATA:  if (w_hs && S_AXI_WLAST)  w_next = W_RESP;
            W_RESP:  if (b_hs)                 w_next = W_ADDR;
            default:                           w_next = W_ADDR;
        endcase
    end

    // Write FSM state and registered write-side outputs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_ADDR;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= 4'd0;
            S_AXI_BRESP   <= RESP_OKAY;
            w_idx         <= '0;
            w_code        <= RESP_OKAY;
        end else begin
            w_state       <= w_next;
            S_AXI_AWREADY <= (w_next == W_ADDR);
            S_AXI_WREADY  <= (w_next == W_DATA);
            S_AXI_BVALID  <= (w_next == W_RESP);
            // BID/BRESP are only visible in W_RESP, so latching them early is safe.
            if (aw_hs) begin
                S_AXI_BID   <= S_AXI_AWID;
                S_AXI_BRESP <= aw_code;
                w_code      <= aw_code;
                w_idx       <= S_AXI_AWADDR[IDX_LSB +: IDX_W];
            end
        end
    end

    // Scratch RAM write: no reset; a beat sampled together with reset is dropped.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESET && w_hs && (w_code == RESP_OKAY))
            mem[w_idx] <= (mem[w_idx] & ~wmask) | (S_AXI_WDATA & wmask);
    end

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_ADDR:  if (ar_hs)               r_next = R_DATA;
            R_DATA:  if (r_hs && S_AXI_RLAST) r_next = R_ADDR;
            default:                          r_next = R_ADDR;
        endcase
    end

    // Read FSM state and registered read-side outputs.
    // RDATA is captured at the AR handshake, so a same-edge write returns old data.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_ADDR;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RID     <= 4'd0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RDATA   <= '0;
            r_len         <= 8'd0;
            r_cnt         <= 8'd0;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= (r_next == R_ADDR);
            S_AXI_RVALID  <= (r_next == R_DATA);
            if (ar_hs) begin
                S_AXI_RID   <= S_AXI_ARID;
                S_AXI_RRESP <= ar_code;
                S_AXI_RDATA <= (ar_code == RESP_OKAY) ? mem[S_AXI_ARADDR[IDX_LSB +: IDX_W]] : '0;
                S_AXI_RLAST <= (S_AXI_ARLEN == 8'd0);
                r_len       <= S_AXI_ARLEN;
                r_cnt       <= 8'd0;
            end else if (r_hs) begin
                if (S_AXI_RLAST) begin
                    S_AXI_RLAST <= 1'b0;
                end else begin
                    r_cnt       <= 8'(r_cnt + 8'd1);
                    S_AXI_RLAST <= (8'(r_cnt + 8'd1) == r_len);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_scratch_slave.sv
// Self-checking bench for axi4_scratch_slave: a table of single transactions
// checked through response scoreboards, plus hand sequences for bursts with
// back-pressure, early write data, a read/write collision and reset in flight.
module tb_axi4_scratch_slave;

    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [1:0]  DECERR = 2'b11;
    localparam logic [63:0] ALL    = '1;

    logic         clk;
    logic         rst;
    logic [33:0]  awaddr, araddr;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [3:0]   awid, bid, arid, rid;
    logic [7:0]   awlen, arlen;
    logic [511:0] wdata, rdata;
    logic [63:0]  wstrb;
    logic [1:0]   bresp, rresp;

    axi4_scratch_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(3'd6), .S_AXI_AWBURST(2'b01), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0),
        .S_AXI_AWQOS(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(3'd6), .S_AXI_ARBURST(2'b01), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0),
        .S_AXI_ARQOS(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RID(rid), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   id;
        logic [1:0]   resp;
        logic         last;
        logic [511:0] data;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    typedef struct {
        bit           wr;
        logic [33:0]  addr;
        logic [3:0]   id;
        logic [7:0]   len;
        logic [511:0] data;
        logic [63:0]  strb;
        logic [1:0]   resp;
    } vec_t;

    rexp_t        rq[$];
    bexp_t        bq[$];
    logic [511:0] model [16];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: compares handshaked beats against the scoreboards and
    // checks that a stalled R beat stays valid and unchanged.
    logic         r_stall = 1'b0;
    logic [511:0] r_hold_data;
    logic [6:0]   r_hold_ctl;
    rexp_t        r_e;
    bexp_t        b_e;
    always @(negedge clk) begin
        if (rst) begin
            r_stall = 1'b0;
        end else begin
            if (r_stall) begin
                check("r_stall_valid", 512'(rvalid), 512'd1);
                check("r_stall_data", rdata, r_hold_data);
                check("r_stall_ctl", 512'({rid, rresp, rlast}), 512'(r_hold_ctl));
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    check("r_unexpected_beat", 512'd1, 512'd0);
                end else begin
                    r_e = rq.pop_front();
                    check("rdata", rdata, r_e.data);
                    check("rresp", 512'(rresp), 512'(r_e.resp));
                    check("rlast", 512'(rlast), 512'(r_e.last));
                    check("rid", 512'(rid), 512'(r_e.id));
                end
            end
            r_stall     = rvalid && !rready;
            r_hold_data = rdata;
            r_hold_ctl  = {rid, rresp, rlast};
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    check("b_unexpected", 512'd1, 512'd0);
                end else begin
                    b_e = bq.pop_front();
                    check("bid", 512'(bid), 512'(b_e.id));
                    check("bresp", 512'(bresp), 512'(b_e.resp));
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 512'(rq.size() + bq.size()), 512'd0);
    endtask

    // One single-beat write; W may be raised pre_w cycles ahead of AW.
    task automatic do_write(input logic [33:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [511:0] d, input logic [63:0] s, input logic [1:0] resp,
                            input int pre_w);
        int n;
        logic [3:0] idx;
        bq.push_back('{id: id, resp: resp});
        wdata = d; wstrb = s; wlast = 1'b1;
        if (pre_w > 0) begin
            wvalid = 1'b1;
            repeat (pre_w) begin
                tick();
                check("w_early_wready", 512'(wready), 512'd0);
            end
        end
        awaddr = a; awid = id; awlen = len; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 100);
        check("aw_wait", 512'(awready), 512'd1);
        check("wready_before_aw", 512'(wready), 512'd0);
        tick();
        awvalid = 1'b0;
        check("wready_latency", 512'(wready), 512'd1);
        tick();
        wvalid = 1'b0;
        check("bvalid_latency", 512'(bvalid), 512'd1);
        if (resp == OKAY) begin
            idx = a[9:6];
            for (int i = 0; i < 64; i++)
                if (s[i]) model[idx][i*8 +: 8] = d[i*8 +: 8];
        end
    endtask

    // One read transaction; expected beats come from the bench model.
    task automatic do_read(input logic [33:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] resp, input bit toggle);
        int n;
        logic [3:0] idx;
        idx = a[9:6];
        for (int i = 0; i <= int'(len); i++)
            rq.push_back('{id: id, resp: resp, last: (i == int'(len)),
                           data: (resp == OKAY) ? model[idx] : 512'd0});
        araddr = a; arid = id; arlen = len; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 100);
        check("ar_wait", 512'(arready), 512'd1);
        tick();
        arvalid = 1'b0;
        check("rvalid_latency", 512'(rvalid), 512'd1);
        n = 0;
        while (rq.size() != 0 && n < 200) begin
            if (toggle) rready = ~rready;
            tick();
            n++;
        end
        rready = 1'b1;
        check("read_timeout", 512'(rq.size()), 512'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; awid = '0; awlen = '0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; arid = '0; arlen = '0; rready = 1'b1;

        vecs.push_back('{1'b1, 34'h000, 4'h1, 8'd0, 512'h12345678, ALL, OKAY});
        vecs.push_back('{1'b0, 34'h000, 4'h2, 8'd0, 512'd0, 64'd0, OKAY});
        vecs.push_back('{1'b1, 34'h0C0, 4'h3, 8'd0, {512{1'b1}}, ALL, OKAY});
        vecs.push_back('{1'b1, 34'h0C0, 4'h4, 8'd0, 512'd0, 64'h1, OKAY});
        vecs.push_back('{1'b0, 34'h0C0, 4'h6, 8'd0, 512'd0, 64'd0, OKAY});
        vecs.push_back('{1'b1, 34'h400, 4'h7, 8'd0, 512'hDEAD, ALL, DECERR});
        vecs.push_back('{1'b0, 34'h400, 4'h8, 8'd0, 512'd0, 64'd0, DECERR});
        vecs.push_back('{1'b0, 34'h000, 4'h9, 8'd0, 512'd0, 64'd0, OKAY});
        vecs.push_back('{1'b1, 34'h3C0, 4'hA, 8'd0, {16{32'hA5A5_0F0F}}, ALL, OKAY});
        vecs.push_back('{1'b0, 34'h3FF, 4'hB, 8'd0, 512'd0, 64'd0, OKAY});
        vecs.push_back('{1'b1, 34'h000, 4'hC, 8'd1, 512'hBAD, ALL, SLVERR});
        vecs.push_back('{1'b0, 34'h000, 4'hD, 8'd0, 512'd0, 64'd0, OKAY});
        vecs.push_back('{1'b0, 34'h200000000, 4'hE, 8'd0, 512'd0, 64'd0, DECERR});

        // Reset values
        repeat (3) tick();
        check("rst_ready", 512'({awready, wready, bvalid, arready, rvalid, rlast}), 512'd0);
        check("rst_ids", 512'({bid, bresp, rid, rresp}), 512'd0);
        check("rst_rdata", rdata, 512'd0);
        rst = 1'b0;
        tick();
        check("post_rst_awready", 512'(awready), 512'd1);
        check("post_rst_arready", 512'(arready), 512'd1);

        foreach (vecs[i]) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].data, vecs[i].strb,
                         vecs[i].resp, 0);
            else
                do_read(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].resp, 1'b0);
            drain();
        end

        // Burst read with RREADY back-pressure: 4 SLVERR beats, RLAST on the last
        do_read(34'h000, 4'hA, 8'd3, SLVERR, 1'b1);
        drain();
        repeat (3) begin
            tick();
            check("burst_no_extra", 512'(rvalid), 512'd0);
        end

        // Write data ahead of the address
        do_write(34'h100, 4'h5, 8'd0, {8{64'h0123_4567_89AB_CDEF}}, ALL, OKAY, 2);
        drain();
        do_read(34'h100, 4'h1, 8'd0, OKAY, 1'b0);
        drain();

        // Same-edge RAM write and AR handshake: read sees old data
        do_write(34'h140, 4'h1, 8'd0, 512'hAAAA_1111, ALL, OKAY, 0);
        drain();
        bq.push_back('{id: 4'h2, resp: OKAY});
        rq.push_back('{id: 4'h3, resp: OKAY, last: 1'b1, data: model[5]});
        awaddr = 34'h140; awid = 4'h2; awlen = 8'd0; awvalid = 1'b1;
        wdata = 512'hBBBB_2222; wstrb = ALL; wlast = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("coll_awready", 512'(awready), 512'd1);
        tick();
        awvalid = 1'b0;
        araddr = 34'h140; arid = 4'h3; arlen = 8'd0; arvalid = 1'b1;
        @(negedge clk);
        check("coll_aligned", 512'({wready, arready}), 512'd3);
        tick();
        wvalid = 1'b0; arvalid = 1'b0;
        model[5] = 512'hBBBB_2222;
        drain();
        do_read(34'h140, 4'h4, 8'd0, OKAY, 1'b0);
        drain();

        // Reset while a write response is stalled
        bready = 1'b0;
        do_write(34'h080, 4'h6, 8'd0, 512'h5555_6666, ALL, OKAY, 0);
        tick();
        check("b_hold", 512'(bvalid), 512'd1);
        rst = 1'b1;
        tick();
        check("rst_abort_bvalid", 512'(bvalid), 512'd0);
        check("rst_abort_ready", 512'({awready, wready, arready, rvalid}), 512'd0);
        bq.delete();
        rst = 1'b0;
        bready = 1'b1;
        tick();
        check("rerst_awready", 512'(awready), 512'd1);
        check("rerst_arready", 512'(arready), 512'd1);
        do_read(34'h080, 4'h7, 8'd0, OKAY, 1'b0);
        drain();
        do_write(34'h080, 4'h8, 8'd0, 512'h7777_8888, ALL, OKAY, 0);
        drain();
        do_read(34'h080, 4'h9, 8'd0, OKAY, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_scratch_slave.md
# axi4_scratch_slave

Single-beat AXI4 slave (responder) exposing a small 512-bit-wide scratch RAM. It is the far end of the team's non-bursting AXI4 master: it accepts AW/W/B and AR/R transactions, stores and returns full 64-byte words with byte-strobe support, and answers bursts and out-of-range addresses with error responses while keeping the protocol legal. It sits behind the interconnect as a bring-up and loopback target.

## Interface
- AXI_DATA_WIDTH, 512, data bus width; 64 bytes per beat.
- AXI_ADDR_WIDTH, 34, address width.
- DEPTH, 16, number of 512-bit words; must be a power of two, at least 2.
- S_AXI_ACLK  in  1  sole clock; everything is on the rising edge.
- S_AXI_ARESET  in  1  reset, synchronous and active-high.
- S_AXI_AWADDR/AWVALID/AWID/AWLEN  in  34/1/4/8  write address channel; AWSIZE, AWBURST, AWLOCK, AWCACHE, AWQOS and AWPROT are accepted and ignored.
- S_AXI_AWREADY  out  1  write-address ready.
- S_AXI_WDATA/WSTRB/WLAST/WVALID  in  512/64/1/1  write data channel.
- S_AXI_WREADY  out  1  write-data ready.
- S_AXI_BID/BRESP/BVALID  out  4/2/1  write response channel.
- S_AXI_BREADY  in  1  write-response ready.
- S_AXI_ARADDR/ARVALID/ARID/ARLEN  in  34/1/4/8  read address channel; ARSIZE, ARBURST, ARLOCK, ARCACHE, ARQOS and ARPROT are ignored.
- S_AXI_ARREADY  out  1  read-address ready.
- S_AXI_RDATA/RID/RRESP/RLAST/RVALID  out  512/4/2/1/1  read data channel.
- S_AXI_RREADY  in  1  read-data ready.

## Operation
- Word index is addr[6 +: log2(DEPTH)]. Address bits [5:0] are ignored.
- An address is in range when every bit above the index field is 0.
- Response codes:
  - OKAY (2'b00): in-range address with LEN == 0.
  - SLVERR (2'b10): LEN != 0, whatever the address.
  - DECERR (2'b11): out-of-range address with LEN == 0.
- The write and read FSMs are fully independent and may be active in the same cycle.
- Write FSM:
  - WA (AWREADY=1): on the AW handshake, latch ID, LEN, index and error code, then go to WD.
  - WD (WREADY=1): every W handshake is accepted.
    - If the error code is OKAY, RAM bytes where WSTRB[i]=1 are written; other bytes keep their value.
    - Errored transactions never modify the RAM.
    - The beat carrying WLAST goes to WB; WLAST is trusted and the beat count is not checked against LEN.
  - WB (BVALID=1): BID is the latched ID and BRESP the latched code. On the B handshake, return to WA.
  - Write data presented before the address waits: WREADY stays 0 outside WD.
- Read FSM:
  - RA (ARREADY=1): on the AR handshake, latch ID, LEN, index and code, clear the beat counter, then go to RD.
  - RD (RVALID=1): RID is the latched ID and RRESP the latched code.
    - RDATA is RAM[index] for OKAY, otherwise all zeros.
    - RLAST = (beat counter == latched LEN).
    - On each R handshake the counter increments; the handshake with RLAST returns to RA.
    - Bursts return exactly LEN+1 beats, all SLVERR.
- The RAM is not cleared by reset; contents are undefined until written.

## Timing
- Reset values while S_AXI_ARESET=1: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RRESP = 0; RDATA = 0.
- First cycle after reset deasserts: AWREADY=1 and ARREADY=1.
- Reset asserted mid-transaction aborts both FSMs to their idle state. Any partially accepted write beat is committed only if its handshake completed before reset.
- All outputs are registered.
- Write latency: AW handshake at cycle N gives WREADY=1 at N+1. WLAST handshake at cycle M gives BVALID=1 at M+1.
- Read latency: AR handshake at cycle N gives RVALID=1 with valid RDATA at N+1.
- Back-to-back throughput: one single-beat write per 3 cycles and one single-beat read per 2 cycles, assuming ready and valid are held high by the master.
- VALID, once raised, holds with stable payload until its handshake (BVALID/RVALID never drop early).
- Same-word collision: if the RAM write (WLAST handshake) and the AR handshake occur in the same cycle, the read returns the old data. A write committed in any earlier cycle is visible to the read.
- The RAM write occurs on the handshake edge itself; a read whose AR handshake is one cycle later sees the new data.

## Test plan
- Write 512'h12345678 to addr 0 with WSTRB all ones, then read addr 0 -> BRESP=OKAY; RDATA=512'h12345678, RRESP=OKAY, RLAST=1, RID = ARID.
- Write 512'hFF..FF to word 3 (addr 0xC0), then write 0 with WSTRB=64'h1 -> readback has byte 0 = 00 and all other bytes = FF.
- Write to addr 0x400 (word 16, out of range) -> BRESP=DECERR and RAM unchanged; read 0x400 -> RDATA=0, RRESP=DECERR.
- ARLEN=3 read of addr 0 with RREADY toggling 1/0 -> exactly 4 beats, all SLVERR with zero data, RLAST only on beat 4; RVALID and payload held stable during stalls.
- WVALID raised 2 cycles before AWVALID with AWLEN=0 -> WREADY stays 0 until the cycle after the AW handshake; BID = AWID = 4'h5.
- Assert reset while BVALID=1 and BREADY=0 -> next cycle BVALID=0; after release AWREADY=1 and ARREADY=1, and a fresh write/read pair completes normally.
